// File: rtl/dp_pkg.sv
// Shared types and helpers for the parametrised sequenced datapath:
// FSM states, opcodes, shift codes and the N/V/Z status calculation.
package dp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADA,
        LOADB,
        EXEC,
        WB
    } state_t;

    typedef enum logic [2:0] {
        OP_MOVI = 3'b000,
        OP_MOV  = 3'b001,
        OP_ADD  = 3'b010,
        OP_CMP  = 3'b011,
        OP_AND  = 3'b100,
        OP_MVN  = 3'b101
    } op_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } status_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'b101;
    endfunction

    function automatic logic op_sets_status(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_CMP) || (op == OP_AND) || (op == OP_MVN);
    endfunction

    // Width-independent: overflow only needs the operand and result sign bits.
    function automatic status_t alu_status(
        input logic [2:0] op,
        input logic       a_msb,
        input logic       b_msb,
        input logic       r_msb,
        input logic       r_zero
    );
        status_t s;
        s.n = r_msb;
        s.z = r_zero;
        case (op)
            OP_ADD:  s.v = (a_msb == b_msb) && (r_msb != a_msb);
            OP_CMP:  s.v = (a_msb != b_msb) && (r_msb != a_msb);
            default: s.v = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dp_shifter.sv
// Combinational B-operand shifter. Defining DP_BARREL_EN selects a barrel
// shifter driven by shamt; otherwise every shift is by exactly one bit.
module dp_shifter
    import dp_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  logic [DATA_W-1:0]  din,
    input  logic [1:0]         shift,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  dout
);

`ifdef DP_BARREL_EN
    logic [31:0] amt;
    logic        too_far;

    assign amt     = 32'(shamt);
    assign too_far = amt >= 32'(DATA_W);

    // NOTE: every branch assigns dout, so this block can never infer a latch.
    always_comb begin
        case (shift)
            SH_LSL:  dout = too_far ? '0 : din << amt;
            SH_LSR:  dout = too_far ? '0 : din >> amt;
            SH_ASR:  dout = $signed(din) >>> amt;
            default: dout = din;
        endcase
    end
`else
    logic shamt_unused;

    assign shamt_unused = ^shamt;

    always_comb begin
        case (shift)
            SH_LSL:  dout = {din[DATA_W-2:0], 1'b0};
            SH_LSR:  dout = {1'b0, din[DATA_W-1:1]};
            SH_ASR:  dout = {din[DATA_W-1], din[DATA_W-1:1]};
            default: dout = din;
        endcase
    end
`endif

endmodule

// File: rtl/param_datapath_seq.sv
// Sequenced register-file datapath: accepts one command per valid/ready
// handshake and walks LOADA/LOADB/EXEC/WB itself. Optional DP_BARREL_EN.
module param_datapath_seq
    import dp_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int NREGS   = 8,
    parameter  int IMM_W   = 8,
    parameter  int SHAMT_W = 4,
    localparam int RN_W    = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [RN_W-1:0]    cmd_rd,
    input  logic [RN_W-1:0]    cmd_rn,
    input  logic [RN_W-1:0]    cmd_rm,
    input  logic [1:0]         cmd_shift,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    input  logic [IMM_W-1:0]   cmd_imm,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  datapath_out,
    output logic               N,
    output logic               V,
    output logic               Z,
    input  logic [RN_W-1:0]    dbg_rnum,
    output logic [DATA_W-1:0]  dbg_rdata
);

    state_t              state;
    logic [2:0]          op_q;
    logic [RN_W-1:0]     rd_q;
    logic [RN_W-1:0]     rn_q;
    logic [RN_W-1:0]     rm_q;
    logic [1:0]          shift_q;
    logic [SHAMT_W-1:0]  shamt_q;
    logic [IMM_W-1:0]    imm_q;
    logic [DATA_W-1:0]   reg_a;
    logic [DATA_W-1:0]   reg_b;
    logic [DATA_W-1:0]   reg_c;
    status_t             status_q;
    logic [DATA_W-1:0]   rf [NREGS];

    logic [DATA_W-1:0]   b_shifted;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   alu_res;
    status_t             alu_st;

    dp_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .din   (reg_b),
        .shift (shift_q),
        .shamt (shamt_q),
        .dout  (b_shifted)
    );

    assign imm_ext = DATA_W'($signed(imm_q));

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_MOVI: alu_res = imm_ext;
            OP_MOV:  alu_res = b_shifted;
            OP_ADD:  alu_res = reg_a + b_shifted;
            OP_CMP:  alu_res = reg_a - b_shifted;
            OP_AND:  alu_res = reg_a & b_shifted;
            OP_MVN:  alu_res = ~b_shifted;
            default: alu_res = '0;
        endcase
    end

    assign alu_st = alu_status(op_q, reg_a[DATA_W-1], b_shifted[DATA_W-1],
                               alu_res[DATA_W-1], alu_res == '0);

    // NOTE: all state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= '0;
            shamt_q  <= '0;
            imm_q    <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            reg_c    <= '0;
            status_q <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            // NOTE: the register file must clear on reset, so it maps to flops, not RAM.
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        rd_q    <= cmd_rd;
                        rn_q    <= cmd_rn;
                        rm_q    <= cmd_rm;
                        shift_q <= cmd_shift;
                        shamt_q <= cmd_shamt;
                        imm_q   <= cmd_imm;
                        if (!op_is_legal(cmd_op)) begin
                            err <= 1'b1;
                        end else if (cmd_op == OP_MOVI) begin
                            state <= EXEC;
                        end else if (cmd_op == OP_MOV || cmd_op == OP_MVN) begin
                            reg_a <= '0;
                            state <= LOADB;
                        end else begin
                            state <= LOADA;
                        end
                    end
                end
                LOADA: begin
                    reg_a <= rf[rn_q];
                    state <= LOADB;
                end
                LOADB: begin
                    reg_b <= rf[rm_q];
                    state <= EXEC;
                end
                EXEC: begin
                    if (op_q != OP_CMP) begin
                        reg_c <= alu_res;
                    end
                    if (op_sets_status(op_q)) begin
                        status_q <= alu_st;
                    end
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    if (op_q != OP_CMP) begin
                        rf[rd_q] <= reg_c;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state == IDLE);
    assign datapath_out = reg_c;
    assign N            = status_q.n;
    assign V            = status_q.v;
    assign Z            = status_q.z;
    assign dbg_rdata    = rf[dbg_rnum];

endmodule

// File: tb/tb_param_datapath_seq.sv
// Directed-vector bench for param_datapath_seq (DATA_W=16, NREGS=8, IMM_W=8,
// SHAMT_W=5); barrel-shift expectations switch on DP_BARREL_EN.
module tb_param_datapath_seq;

    localparam int DATA_W  = 16;
    localparam int NREGS   = 8;
    localparam int IMM_W   = 8;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] MOVI = 3'b000;
    localparam logic [2:0] MOV  = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] CMP  = 3'b011;
    localparam logic [2:0] AND  = 3'b100;
    localparam logic [2:0] MVN  = 3'b101;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] LSL  = 2'b01;
    localparam logic [1:0] LSR  = 2'b10;
    localparam logic [1:0] ASR  = 2'b11;

`ifdef DP_BARREL_EN
    localparam logic [15:0] EXP_ASR20 = 16'hFFFF;
    localparam logic [15:0] EXP_LSR20 = 16'h0000;
    localparam logic [15:0] EXP_ASR0  = 16'hFF80;
`else
    localparam logic [15:0] EXP_ASR20 = 16'hFFC0;
    localparam logic [15:0] EXP_LSR20 = 16'h7FC0;
    localparam logic [15:0] EXP_ASR0  = 16'hFFC0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [2:0]         cmd_rd;
    logic [2:0]         cmd_rn;
    logic [2:0]         cmd_rm;
    logic [1:0]         cmd_shift;
    logic [SHAMT_W-1:0] cmd_shamt;
    logic [IMM_W-1:0]   cmd_imm;
    logic               done;
    logic               err;
    logic [DATA_W-1:0]  datapath_out;
    logic               N;
    logic               V;
    logic               Z;
    logic [2:0]         dbg_rnum;
    logic [DATA_W-1:0]  dbg_rdata;

    int n_vec = 0;
    int n_bad = 0;

    param_datapath_seq #(
        .DATA_W  (DATA_W),
        .NREGS   (NREGS),
        .IMM_W   (IMM_W),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rn       (cmd_rn),
        .cmd_rm       (cmd_rm),
        .cmd_shift    (cmd_shift),
        .cmd_shamt    (cmd_shamt),
        .cmd_imm      (cmd_imm),
        .done         (done),
        .err          (err),
        .datapath_out (datapath_out),
        .N            (N),
        .V            (V),
        .Z            (Z),
        .dbg_rnum     (dbg_rnum),
        .dbg_rdata    (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        dbg_rnum = idx;
        #1;
        check(tag, 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic check_nvz(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, N, V, Z}, {29'd0, exp});
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] sh,
                         input logic [SHAMT_W-1:0] amt, input logic [IMM_W-1:0] imm);
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rn    = rn;
        cmd_rm    = rm;
        cmd_shift = sh;
        cmd_shamt = amt;
        cmd_imm   = imm;
    endtask

    // Issues one command, measures accept-to-done latency, and returns in the
    // IDLE cycle after WB so the written register is visible on dbg_rdata.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                           input logic [SHAMT_W-1:0] amt, input logic [IMM_W-1:0] imm,
                           input int exp_lat);
        int   cyc;
        logic busy_ready;
        @(negedge clk);
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        drive(op, rd, rn, rm, sh, amt, imm);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cyc        = 1;
        busy_ready = 1'b0;
        while (!done && cyc < 20) begin
            busy_ready |= cmd_ready;
            @(negedge clk);
            cyc++;
        end
        busy_ready |= cmd_ready;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " busy ready"}, 32'(busy_ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] done_vec;
        logic [9:0] ready_vec;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        dbg_rnum  = '0;
        drive(MOVI, 0, 0, 0, NONE, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset ready", 32'(cmd_ready), 32'd1);
        check("reset out", 32'(datapath_out), 32'd0);
        check_nvz("reset nvz", 3'b000);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check_reg("reset r5", 3'd5, 16'h0000);

        // MOVI / ADD with LSL: 2 + (7 << 1) = 16
        run_cmd("movi r0", MOVI, 3'd0, 3'd0, 3'd0, NONE, 0, 8'd7, 2);
        check_reg("r0=7", 3'd0, 16'd7);
        run_cmd("movi r1", MOVI, 3'd1, 3'd0, 3'd0, NONE, 0, 8'd2, 2);
        run_cmd("add r2", ADD, 3'd2, 3'd1, 3'd0, LSL, 1, 8'd0, 4);
        check_reg("add r2=16", 3'd2, 16'd16);
        check("add out", 32'(datapath_out), 32'd16);
        check_nvz("add nvz", 3'b000);

        // CMP sets Z and leaves C alone; MOV must not touch status
        run_cmd("cmp r0r0", CMP, 3'd0, 3'd0, 3'd0, NONE, 0, 8'd0, 4);
        check_nvz("cmp eq nvz", 3'b001);
        check("cmp keeps c", 32'(datapath_out), 32'd16);
        run_cmd("movi r3", MOVI, 3'd3, 3'd0, 3'd0, NONE, 0, 8'd42, 2);
        run_cmd("mov r7", MOV, 3'd7, 3'd0, 3'd3, NONE, 0, 8'd0, 3);
        check_reg("mov r7=42", 3'd7, 16'd42);
        check("mov out", 32'(datapath_out), 32'd42);
        check_nvz("mov keeps nvz", 3'b001);

        // Build 0x4000 by repeated LSL, then overflow into the sign bit
        run_cmd("movi r4", MOVI, 3'd4, 3'd0, 3'd0, NONE, 0, 8'd64, 2);
        for (int i = 0; i < 8; i++) begin
            run_cmd("mov r4 lsl", MOV, 3'd4, 3'd0, 3'd4, LSL, 1, 8'd0, 3);
        end
        check_reg("r4=4000", 3'd4, 16'h4000);
        run_cmd("add ovf", ADD, 3'd5, 3'd4, 3'd4, NONE, 0, 8'd0, 4);
        check_reg("r5=8000", 3'd5, 16'h8000);
        check_nvz("add ovf nvz", 3'b110);
        run_cmd("cmp ovf", CMP, 3'd0, 3'd5, 3'd4, NONE, 0, 8'd0, 4);
        check_nvz("cmp ovf nvz", 3'b010);
        check("cmp ovf keeps c", 32'(datapath_out), 32'h8000);
        check_reg("cmp no write", 3'd0, 16'd7);
        run_cmd("and", AND, 3'd6, 3'd5, 3'd4, NONE, 0, 8'd0, 4);
        check_reg("and r6=0", 3'd6, 16'h0000);
        check_nvz("and nvz", 3'b001);
        run_cmd("mvn", MVN, 3'd6, 3'd0, 3'd0, NONE, 0, 8'd0, 3);
        check_reg("mvn r6", 3'd6, 16'hFFF8);
        check_nvz("mvn nvz", 3'b100);

        // Sign extension and shifter corners
        run_cmd("movi neg", MOVI, 3'd0, 3'd0, 3'd0, NONE, 0, 8'h80, 2);
        check_reg("r0=ff80", 3'd0, 16'hFF80);
        run_cmd("asr1", MOV, 3'd1, 3'd0, 3'd0, ASR, 1, 8'd0, 3);
        check_reg("asr1", 3'd1, 16'hFFC0);
        run_cmd("lsr1", MOV, 3'd1, 3'd0, 3'd0, LSR, 1, 8'd0, 3);
        check_reg("lsr1", 3'd1, 16'h7FC0);
        run_cmd("lsl1", MOV, 3'd1, 3'd0, 3'd0, LSL, 1, 8'd0, 3);
        check_reg("lsl1", 3'd1, 16'hFF00);
        run_cmd("asr20", MOV, 3'd1, 3'd0, 3'd0, ASR, 20, 8'd0, 3);
        check_reg("asr20", 3'd1, EXP_ASR20);
        run_cmd("lsr20", MOV, 3'd1, 3'd0, 3'd0, LSR, 20, 8'd0, 3);
        check_reg("lsr20", 3'd1, EXP_LSR20);
        run_cmd("asr0", MOV, 3'd1, 3'd0, 3'd0, ASR, 0, 8'd0, 3);
        check_reg("asr0", 3'd1, EXP_ASR0);
        run_cmd("none5", MOV, 3'd1, 3'd0, 3'd0, NONE, 5, 8'd0, 3);
        check_reg("none ignores shamt", 3'd1, 16'hFF80);

        // Illegal opcode: err pulse only, nothing else moves
        @(negedge clk);
        drive(3'b110, 3'd0, 3'd0, 3'd0, NONE, 0, 8'h55);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("illegal err", 32'(err), 32'd1);
        check("illegal done", 32'(done), 32'd0);
        check("illegal ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("illegal err width", 32'(err), 32'd0);
        check("illegal done later", 32'(done), 32'd0);
        check_reg("illegal r0", 3'd0, 16'hFF80);
        check_nvz("illegal nvz", 3'b100);
        check("illegal out", 32'(datapath_out), 32'hFF80);

        // cmd_valid held through a busy ADD: MOVI waits for the next IDLE
        @(negedge clk);
        drive(ADD, 3'd2, 3'd0, 3'd0, NONE, 0, 8'd0);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(MOVI, 3'd3, 3'd0, 3'd0, NONE, 0, 8'd5);
        done_vec  = '0;
        ready_vec = '0;
        for (int n = 1; n <= 9; n++) begin
            done_vec[n]  = done;
            ready_vec[n] = cmd_ready;
            if (n == 4) check_reg("hold r3 busy", 3'd3, 16'd42);
            if (n == 6) cmd_valid = 1'b0;
            @(negedge clk);
        end
        check("hold done pattern", 32'(done_vec), 32'h090);
        check("hold ready pattern", 32'(ready_vec), 32'h320);
        check_reg("hold add r2", 3'd2, 16'hFF00);
        check_reg("hold movi r3", 3'd3, 16'd5);
        check_nvz("hold nvz", 3'b100);

        // Reset in EXEC of an ADD: abandons the write and clears everything
        @(negedge clk);
        drive(ADD, 3'd2, 3'd0, 3'd0, NONE, 0, 8'd0);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst ready", 32'(cmd_ready), 32'd1);
        check("rst out", 32'(datapath_out), 32'd0);
        check_nvz("rst nvz", 3'b000);
        check("rst done", 32'(done), 32'd0);
        check_reg("rst r2", 3'd2, 16'h0000);
        check_reg("rst r0", 3'd0, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("rst no late done", 32'(done), 32'd0);
        run_cmd("post-rst movi", MOVI, 3'd1, 3'd0, 3'd0, NONE, 0, 8'hFF, 2);
        check_reg("post-rst r1", 3'd1, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
